// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register outstanding-write scoreboard with issue hazard detection and drain FSM
module reg_scoreboard #(
   parameter int N_REG  = 16,
   parameter int W_ADDR = 4,
   parameter int W_CNT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid_i,
   input  logic [W_ADDR-1:0] issue_rd_i,
   input  logic [W_ADDR-1:0] issue_rs_i,
   input  logic              use_rd_i,
   input  logic              use_rs_i,
   input  logic              wr_rd_i,
   input  logic              stall_i,
   input  logic              wb_i,
   input  logic [W_ADDR-1:0] wb_r_i,
   input  logic              drain_i,
   output logic              issue_fire_o,
   output logic              stall_o,
   output logic [N_REG-1:0]  busy_o,
   output logic              drain_done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam logic [W_CNT-1:0] CNT_MAX = '1;

   state_t           state;
   logic [W_CNT-1:0] cnt [N_REG];

   logic             rd_ok, rs_ok, wb_ok;
   logic [W_CNT-1:0] rd_cnt, rs_cnt, wb_cnt;
   logic             hazard;
   logic             inc_en;
   logic             wb_en;
   logic             same_reg;
   logic             all_zero;

   // Addresses beyond N_REG read as an idle counter and never update state.
   always_comb begin
      rd_ok  = int'(issue_rd_i) < N_REG;
      rs_ok  = int'(issue_rs_i) < N_REG;
      wb_ok  = int'(wb_r_i) < N_REG;
      rd_cnt = rd_ok ? cnt[issue_rd_i] : '0;
      rs_cnt = rs_ok ? cnt[issue_rs_i] : '0;
      wb_cnt = wb_ok ? cnt[wb_r_i] : '0;
   end

   always_comb begin
      busy_o = '0;
      for (int i = 0; i < N_REG; i++) begin
         busy_o[i] = (cnt[i] != '0);
      end
   end

   assign all_zero = (busy_o == '0);

   // Hazard uses registered counts only; a same-cycle write-back does not bypass.
   assign hazard = issue_valid_i &
                   ((use_rd_i & (rd_cnt != '0)) |
                    (use_rs_i & (rs_cnt != '0)) |
                    (wr_rd_i  & (rd_cnt == CNT_MAX)));

   assign issue_fire_o = issue_valid_i & ~hazard & ~stall_i & (state == RUN);
   assign stall_o      = stall_i | hazard | (issue_valid_i & (state != RUN));

   assign inc_en   = issue_fire_o & wr_rd_i & rd_ok;
   assign wb_en    = wb_i & wb_ok;
   assign same_reg = inc_en & wb_en & (issue_rd_i == wb_r_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REG; i++) begin
            cnt[i] <= '0;
         end
         state        <= RUN;
         err_o        <= 1'b0;
         drain_done_o <= 1'b0;
      end else begin
         for (int i = 0; i < N_REG; i++) begin
            if (same_reg && (issue_rd_i == W_ADDR'(i))) begin
               cnt[i] <= cnt[i];
            end else if (inc_en && (issue_rd_i == W_ADDR'(i))) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (wb_en && (wb_r_i == W_ADDR'(i)) && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end

         // Underflow on an idle register or a write-back outside the tracked range.
         if (wb_i && (!wb_ok || ((wb_cnt == '0) && !same_reg))) begin
            err_o <= 1'b1;
         end

         case (state)
            RUN: begin
               drain_done_o <= 1'b0;
               if (drain_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (all_zero) begin
                  state        <= DONE;
                  drain_done_o <= 1'b1;
               end
            end
            DONE: begin
               state        <= RUN;
               drain_done_o <= 1'b0;
            end
            default: begin
               state        <= RUN;
               drain_done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid_i;
   logic [3:0]  issue_rd_i;
   logic [3:0]  issue_rs_i;
   logic        use_rd_i;
   logic        use_rs_i;
   logic        wr_rd_i;
   logic        stall_i;
   logic        wb_i;
   logic [3:0]  wb_r_i;
   logic        drain_i;
   logic        issue_fire_o;
   logic        stall_o;
   logic [15:0] busy_o;
   logic        drain_done_o;
   logic        err_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid_i(issue_valid_i),
      .issue_rd_i   (issue_rd_i),
      .issue_rs_i   (issue_rs_i),
      .use_rd_i     (use_rd_i),
      .use_rs_i     (use_rs_i),
      .wr_rd_i      (wr_rd_i),
      .stall_i      (stall_i),
      .wb_i         (wb_i),
      .wb_r_i       (wb_r_i),
      .drain_i      (drain_i),
      .issue_fire_o (issue_fire_o),
      .stall_o      (stall_o),
      .busy_o       (busy_o),
      .drain_done_o (drain_done_o),
      .err_o        (err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid_i = 1'b0;
      issue_rd_i    = 4'd0;
      issue_rs_i    = 4'd0;
      use_rd_i      = 1'b0;
      use_rs_i      = 1'b0;
      wr_rd_i       = 1'b0;
      stall_i       = 1'b0;
      wb_i          = 1'b0;
      wb_r_i        = 4'd0;
      drain_i       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_wr(input logic [3:0] rd);
      issue_valid_i = 1'b1;
      issue_rd_i    = rd;
      wr_rd_i       = 1'b1;
      use_rd_i      = 1'b0;
      use_rs_i      = 1'b0;
   endtask

   task automatic wb(input logic [3:0] r);
      wb_i   = 1'b1;
      wb_r_i = r;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("rst_busy", busy_o, 16'h0000);
      check("rst_err", err_o, 0);
      check("rst_done", drain_done_o, 0);
      check("rst_stall", stall_o, 0);

      // Single write then write-back to r3
      tick();
      issue_wr(4'd3);
      @(negedge clk);
      check("r3_fire", issue_fire_o, 1);
      tick();
      idle();
      @(negedge clk);
      check("r3_busy", busy_o, 16'h0008);
      tick();
      wb(4'd3);
      tick();
      idle();
      @(negedge clk);
      check("r3_clear", busy_o, 16'h0000);
      check("r3_err", err_o, 0);

      // RAW on r5 with same-cycle write-back (no bypass)
      tick();
      issue_wr(4'd5);
      @(negedge clk);
      check("r5_fire", issue_fire_o, 1);
      tick();
      idle();
      issue_valid_i = 1'b1;
      issue_rs_i    = 4'd5;
      use_rs_i      = 1'b1;
      wb(4'd5);
      @(negedge clk);
      check("raw_stall", stall_o, 1);
      check("raw_nofire", issue_fire_o, 0);
      tick();
      wb_i = 1'b0;
      @(negedge clk);
      check("raw_stall_clr", stall_o, 0);
      check("raw_fire", issue_fire_o, 1);
      tick();
      idle();

      // WAW saturation on r2
      for (int i = 0; i < 3; i++) begin
         issue_wr(4'd2);
         @(negedge clk);
         check("waw_fire", issue_fire_o, 1);
         tick();
      end
      @(negedge clk);
      check("waw_max_stall", stall_o, 1);
      check("waw_max_nofire", issue_fire_o, 0);
      check("waw_busy", busy_o, 16'h0004);
      tick();
      wb(4'd2);
      @(negedge clk);
      check("waw_wb_stall", stall_o, 1);
      tick();
      wb_i = 1'b0;
      @(negedge clk);
      check("waw_resume", issue_fire_o, 1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         wb(4'd2);
         tick();
      end
      idle();
      @(negedge clk);
      check("waw_clear", busy_o, 16'h0000);
      check("waw_err", err_o, 0);

      // Same-register increment and write-back nets to zero change
      tick();
      issue_wr(4'd7);
      tick();
      issue_wr(4'd7);
      wb(4'd7);
      @(negedge clk);
      check("r7_fire", issue_fire_o, 1);
      tick();
      idle();
      @(negedge clk);
      check("r7_hold", busy_o, 16'h0080);
      check("r7_err", err_o, 0);
      tick();
      wb(4'd7);
      tick();
      idle();
      @(negedge clk);
      check("r7_clear", busy_o, 16'h0000);
      check("r7_err2", err_o, 0);

      // Increment and write-back to different registers
      tick();
      issue_wr(4'd4);
      tick();
      issue_wr(4'd6);
      wb(4'd4);
      tick();
      idle();
      @(negedge clk);
      check("diff_busy", busy_o, 16'h0040);
      tick();
      wb(4'd6);
      tick();
      idle();
      @(negedge clk);
      check("diff_clear", busy_o, 16'h0000);

      // Drain with one outstanding write on r1
      tick();
      issue_wr(4'd1);
      tick();
      idle();
      drain_i = 1'b1;
      tick();
      idle();
      issue_valid_i = 1'b1;
      @(negedge clk);
      check("drain_block", issue_fire_o, 0);
      check("drain_stall", stall_o, 1);
      check("drain_busy", busy_o, 16'h0002);
      tick();
      wb(4'd1);
      drain_i = 1'b1;
      tick();
      wb_i    = 1'b0;
      drain_i = 1'b0;
      @(negedge clk);
      check("drain_busy0", busy_o, 16'h0000);
      check("drain_not_yet", drain_done_o, 0);
      check("drain_block2", issue_fire_o, 0);
      tick();
      @(negedge clk);
      check("drain_done", drain_done_o, 1);
      check("done_block", issue_fire_o, 0);
      tick();
      @(negedge clk);
      check("done_pulse_end", drain_done_o, 0);
      check("run_resume", issue_fire_o, 1);
      check("run_stall", stall_o, 0);
      tick();
      idle();

      // Drain entered with nothing outstanding
      drain_i = 1'b1;
      tick();
      drain_i = 1'b0;
      @(negedge clk);
      check("empty_drain_wait", drain_done_o, 0);
      tick();
      @(negedge clk);
      check("empty_drain_done", drain_done_o, 1);
      tick();
      @(negedge clk);
      check("empty_drain_end", drain_done_o, 0);
      check("empty_err", err_o, 0);

      // Underflow on idle r9 is sticky
      tick();
      wb(4'd9);
      tick();
      idle();
      @(negedge clk);
      check("uf_err", err_o, 1);
      tick();
      tick();
      @(negedge clk);
      check("uf_sticky", err_o, 1);
      do_reset();
      @(negedge clk);
      check("uf_rst", err_o, 0);

      // Reset discards outstanding r8; later write-back underflows
      tick();
      issue_wr(4'd8);
      tick();
      idle();
      @(negedge clk);
      check("r8_busy", busy_o, 16'h0100);
      tick();
      rst = 1'b1;
      issue_wr(4'd10);
      wb(4'd8);
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("rst_prio_busy", busy_o, 16'h0000);
      check("rst_prio_err", err_o, 0);
      tick();
      wb(4'd8);
      tick();
      idle();
      @(negedge clk);
      check("post_rst_uf", err_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
